// File: rtl/restoring_divider_4_bit.sv
// Sequential restoring divider: one quotient bit per clock, shift-subtract on a
// WIDTH+1 bit partial remainder, with a start/busy/done handshake.
module restoring_divider_4_bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [WIDTH:0]   m_ext, m_inv, a_sh, t, a_new;
  logic [WIDTH-1:0] q_new;

  // Subtraction reuses the adder: A - M = A + ~M + 1 at WIDTH+1 bits.
  assign m_ext = {1'b0, m_q};
  generate
    for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_inv
      assign m_inv[gi] = ~m_ext[gi];
    end
  endgenerate

  assign a_sh  = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign t     = a_sh + m_inv + {{WIDTH{1'b0}}, 1'b1};
  // A negative trial result restores the shifted value and yields a 0 bit.
  assign a_new = t[WIDTH] ? a_sh : t;
  assign q_new = {q_q[WIDTH-2:0], ~t[WIDTH]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    count_d = count_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    dz_d    = dz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (divisor != '0) begin
            m_d     = divisor;
            q_d     = dividend;
            a_d     = '0;
            count_d = CW'(WIDTH);
            busy_d  = 1'b1;
            state_d = S_RUN;
          end else begin
            quot_d  = '1;
            rem_d   = dividend;
            dz_d    = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d     = a_new;
        q_d     = q_new;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          quot_d  = q_new;
          rem_d   = a_new[WIDTH-1:0];
          dz_d    = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_restoring_divider_4_bit.sv
// Directed bench for restoring_divider_4_bit: handshake timing, results,
// divide-by-zero, ignored starts, back-to-back operation and mid-run reset.
module tb_restoring_divider_4_bit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int compared;
  int mismatched;

  restoring_divider_4_bit #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issues one start, then follows the handshake to the done cycle.
  task automatic do_div(input logic [3:0] dvd, input logic [3:0] dsr,
                        input logic [3:0] eq, input logic [3:0] er,
                        input logic ez, input int elat);
    int lat;
    int nbusy;
    bit seen;
    start    = 1'b1;
    dividend = dvd;
    divisor  = dsr;
    step();
    start    = 1'b0;
    dividend = 4'($urandom);
    divisor  = 4'($urandom);
    lat   = 1;
    nbusy = 0;
    seen  = 1'b0;
    while (!seen && lat <= 20) begin
      check("busy_done_excl", {31'd0, busy & done}, 32'd0);
      if (done) seen = 1'b1;
      else begin
        if (busy) nbusy++;
        step();
        lat++;
      end
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    check("latency", lat, elat);
    check("busy_cycles", nbusy, elat - 1);
    check("quotient", {28'd0, quotient}, {28'd0, eq});
    check("remainder", {28'd0, remainder}, {28'd0, er});
    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, ez});
    $display("div %0d / %0d -> q=%0d r=%0d dz=%0d lat=%0d", dvd, dsr, quotient, remainder,
             div_by_zero, lat);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    start      = 1'b0;
    dividend   = 4'd0;
    divisor    = 4'd0;
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quot", {28'd0, quotient}, 32'd0);
    check("rst_rem", {28'd0, remainder}, 32'd0);
    check("rst_dz", {31'd0, div_by_zero}, 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    do_div(4'd13, 4'd4, 4'd3, 4'd1, 1'b0, 5);
    step();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("hold_quot", {28'd0, quotient}, 32'd3);
    check("hold_rem", {28'd0, remainder}, 32'd1);

    do_div(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 5);
    do_div(4'd5, 4'd7, 4'd0, 4'd5, 1'b0, 5);
    do_div(4'd0, 4'd3, 4'd0, 4'd0, 1'b0, 5);
    step();

    do_div(4'd9, 4'd0, 4'd15, 4'd9, 1'b1, 1);
    step();
    check("dz_done_low", {31'd0, done}, 32'd0);
    check("dz_hold", {31'd0, div_by_zero}, 32'd1);

    // Second start raised during RUN must be ignored.
    start = 1'b1; dividend = 4'd12; divisor = 4'd5;
    step();
    dividend = 4'd3; divisor = 4'd1;
    check("run_busy", {31'd0, busy}, 32'd1);
    step();
    step();
    start = 1'b0;
    step();
    check("run_no_done", {31'd0, done}, 32'd0);
    step();
    check("ignored_done", {31'd0, done}, 32'd1);
    check("ignored_quot", {28'd0, quotient}, 32'd2);
    check("ignored_rem", {28'd0, remainder}, 32'd2);
    for (int i = 0; i < 6; i++) begin
      step();
      check("no_extra_done", {31'd0, done | busy}, 32'd0);
    end

    // Back-to-back: second start lands in the done cycle of the first.
    do_div(4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 5);
    do_div(4'd11, 4'd2, 4'd5, 4'd1, 1'b0, 5);
    step();

    // Reset two cycles into a run.
    start = 1'b1; dividend = 4'd15; divisor = 4'd2;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_quot", {28'd0, quotient}, 32'd0);
    check("mid_rst_rem", {28'd0, remainder}, 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("post_rst_idle", {31'd0, done | busy}, 32'd0);
    end
    do_div(4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 5);
    step();

    // Full sweep of non-zero divisors against integer division.
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        do_div(4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0, 5);
        check("invariant", quotient * b + remainder, a);
        check("rem_lt_div", {31'd0, remainder < 4'(b)}, 32'd1);
      end
    end
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
